// File: rtl/sobel_sequencer.sv
// ---------------------------------------------------------------------------
// sobel_sequencer
//
// Top-level control for the Sobel edge-detection datapath. A host job
// (image width/length, source/destination base addresses) is latched and
// handed to the move_control address generator. The sequencer then loops
// read -> compute -> write -> move over every window position until
// move_control reports the scan complete, and finally pulses done.
//
// Optional feature (compile-time macro): SOBEL_SEQ_WATCHDOG_EN
//   When defined, every wait state (CONFIG, READ, CALC, WRITE, MOVE) is
//   bounded to WDOG_CYCLES cycles; on expiry all strobes drop, err is set
//   and the job finishes with a normal done pulse. When undefined there is
//   no counter and waits are unbounded.
//
// Ports:
//   clk, n_reset         system clock, asynchronous active-low reset
//   start                host job request, sampled only in IDLE
//   cfg_width/length     image dimensions in pixels
//   cfg_src/cfg_dst      source/destination base addresses
//   busy, done, err      job status (done is a one-cycle pulse, err sticky)
//   mc_width/length      latched dimensions to move_control
//   mc_initial_addr_r/w  latched base addresses to move_control
//   mc_load_initial      level request, held until mc_load_done
//   mc_start_move        level request, held until mc_move_done
//   mc_load_done/move_done/all_done  move_control handshakes
//   mem_read_en/write_en shared memory strobes, held while mem_busy
//   mem_busy             memory stall
//   calc_start/calc_done Sobel kernel handshake
//   win_count            windows written this job (saturating)
// ---------------------------------------------------------------------------
module sobel_sequencer #(
  parameter int ADDR_W        = 8,
  parameter int DIM_W         = 12,
  parameter int READS_PER_WIN = 3
`ifdef SOBEL_SEQ_WATCHDOG_EN
  , parameter int WDOG_CYCLES = 255
`endif
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 start,
  input  logic [DIM_W-1:0]     cfg_width,
  input  logic [DIM_W-1:0]     cfg_length,
  input  logic [ADDR_W-1:0]    cfg_src,
  input  logic [ADDR_W-1:0]    cfg_dst,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [DIM_W-1:0]     mc_width,
  output logic [DIM_W-1:0]     mc_length,
  output logic [ADDR_W-1:0]    mc_initial_addr_r,
  output logic [ADDR_W-1:0]    mc_initial_addr_w,
  output logic                 mc_load_initial,
  output logic                 mc_start_move,
  input  logic                 mc_load_done,
  input  logic                 mc_move_done,
  input  logic                 mc_all_done,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  input  logic                 mem_busy,
  output logic                 calc_start,
  input  logic                 calc_done,
  output logic [2*DIM_W-1:0]   win_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_READ,
    S_CALC,
    S_WRITE,
    S_MOVE,
    S_FINISH
  } state_t;

  localparam int RD_W = (READS_PER_WIN > 1) ? $clog2(READS_PER_WIN) : 1;
  localparam logic [RD_W-1:0]  RD_LAST = RD_W'(READS_PER_WIN - 1);
  // A 3x3 kernel needs at least three pixels in each direction.
  localparam logic [DIM_W-1:0] MIN_DIM = DIM_W'(3);

  state_t          state;
  logic [RD_W-1:0] rd_cnt;
  logic            wdog_expired;

`ifdef SOBEL_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  state_t          wdog_state;
  logic [WD_W-1:0] wdog_cnt;
  logic            in_wait;

  assign in_wait = (state == S_CONFIG) || (state == S_READ) || (state == S_CALC) ||
                   (state == S_WRITE)  || (state == S_MOVE);

  // wdog_cnt holds the number of completed cycles in the current state; a
  // state change (state differs from last cycle's) restarts the count.
  assign wdog_expired = in_wait && (state == wdog_state) &&
                        (wdog_cnt == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wdog_state <= S_IDLE;
      wdog_cnt   <= '0;
    end else begin
      wdog_state <= state;
      if (state != wdog_state) wdog_cnt <= WD_W'(1);
      else                     wdog_cnt <= wdog_cnt + 1'b1;
    end
  end
`else
  assign wdog_expired = 1'b0;
`endif

  // Main sequencer. All outputs are registered and set on the transition
  // into the state that owns them, so each strobe is high for exactly the
  // cycles the owning state is active.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state             <= S_IDLE;
      rd_cnt            <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      mc_width          <= '0;
      mc_length         <= '0;
      mc_initial_addr_r <= '0;
      mc_initial_addr_w <= '0;
      mc_load_initial   <= 1'b0;
      mc_start_move     <= 1'b0;
      mem_read_en       <= 1'b0;
      mem_write_en      <= 1'b0;
      calc_start        <= 1'b0;
      win_count         <= '0;
    end else begin
      done       <= 1'b0;
      calc_start <= 1'b0;
      if (wdog_expired) begin
        mc_load_initial <= 1'b0;
        mc_start_move   <= 1'b0;
        mem_read_en     <= 1'b0;
        mem_write_en    <= 1'b0;
        err             <= 1'b1;
        state           <= S_FINISH;
      end else begin
        case (state)
          S_IDLE: begin
            busy <= 1'b0;
            if (start) begin
              busy              <= 1'b1;
              err               <= 1'b0;
              win_count         <= '0;
              mc_width          <= cfg_width;
              mc_length         <= cfg_length;
              mc_initial_addr_r <= cfg_src;
              mc_initial_addr_w <= cfg_dst;
              if ((cfg_width < MIN_DIM) || (cfg_length < MIN_DIM)) begin
                err   <= 1'b1;
                state <= S_FINISH;
              end else begin
                mc_load_initial <= 1'b1;
                state           <= S_CONFIG;
              end
            end
          end
          S_CONFIG: begin
            if (mc_load_done) begin
              mc_load_initial <= 1'b0;
              mem_read_en     <= 1'b1;
              rd_cnt          <= '0;
              state           <= S_READ;
            end
          end
          S_READ: begin
            // Every cycle with the strobe up and no stall is one accepted read.
            if (!mem_busy) begin
              if (rd_cnt == RD_LAST) begin
                mem_read_en <= 1'b0;
                calc_start  <= 1'b1;
                state       <= S_CALC;
              end else begin
                rd_cnt <= rd_cnt + 1'b1;
              end
            end
          end
          S_CALC: begin
            // calc_start is high only in the first CALC cycle; a result
            // arriving in that same cycle is accepted.
            if (calc_done) begin
              mem_write_en <= 1'b1;
              state        <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (!mem_busy) begin
              mem_write_en <= 1'b0;
              if (win_count != '1) win_count <= win_count + 1'b1;
              if (mc_all_done) begin
                state <= S_FINISH;
              end else begin
                mc_start_move <= 1'b1;
                state         <= S_MOVE;
              end
            end
          end
          S_MOVE: begin
            // If all_done rises together with move_done, the window just
            // moved to is still processed; WRITE then sees all_done.
            if (mc_move_done) begin
              mc_start_move <= 1'b0;
              mem_read_en   <= 1'b1;
              rd_cnt        <= '0;
              state         <= S_READ;
            end
          end
          S_FINISH: begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sobel_sequencer.sv
module tb_sobel_sequencer;

  localparam int ADDR_W = 8;
  localparam int DIM_W  = 12;
  localparam int RPW    = 3;
  localparam int WCW    = 2 * DIM_W;

  logic              clk;
  logic              n_reset;
  logic              start;
  logic [DIM_W-1:0]  cfg_width;
  logic [DIM_W-1:0]  cfg_length;
  logic [ADDR_W-1:0] cfg_src;
  logic [ADDR_W-1:0] cfg_dst;
  logic              busy;
  logic              done;
  logic              err;
  logic [DIM_W-1:0]  mc_width;
  logic [DIM_W-1:0]  mc_length;
  logic [ADDR_W-1:0] mc_initial_addr_r;
  logic [ADDR_W-1:0] mc_initial_addr_w;
  logic              mc_load_initial;
  logic              mc_start_move;
  logic              mc_load_done;
  logic              mc_move_done;
  logic              mc_all_done;
  logic              mem_read_en;
  logic              mem_write_en;
  logic              mem_busy;
  logic              calc_start;
  logic              calc_done;
  logic [WCW-1:0]    win_count;

  sobel_sequencer #(
    .ADDR_W(ADDR_W),
    .DIM_W(DIM_W),
    .READS_PER_WIN(RPW)
`ifdef SOBEL_SEQ_WATCHDOG_EN
    , .WDOG_CYCLES(16)
`endif
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .start(start),
    .cfg_width(cfg_width),
    .cfg_length(cfg_length),
    .cfg_src(cfg_src),
    .cfg_dst(cfg_dst),
    .busy(busy),
    .done(done),
    .err(err),
    .mc_width(mc_width),
    .mc_length(mc_length),
    .mc_initial_addr_r(mc_initial_addr_r),
    .mc_initial_addr_w(mc_initial_addr_w),
    .mc_load_initial(mc_load_initial),
    .mc_start_move(mc_start_move),
    .mc_load_done(mc_load_done),
    .mc_move_done(mc_move_done),
    .mc_all_done(mc_all_done),
    .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en),
    .mem_busy(mem_busy),
    .calc_start(calc_start),
    .calc_done(calc_done),
    .win_count(win_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Environment models: move_control, memory stall generator, Sobel kernel.
  int   moves_target = 8;
  int   move_cnt;
  bit   stall_mode = 0;
  bit   calc_hang = 0;
  bit   calc_fast = 0;
  int   stall_left;
  int   model_rd;
  logic calc_done_q;

  assign mem_busy  = (stall_left != 0);
  assign calc_done = calc_hang ? 1'b0 : (calc_fast ? calc_start : calc_done_q);

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mc_load_done <= 1'b0;
      mc_move_done <= 1'b0;
      mc_all_done  <= 1'b0;
      move_cnt     <= 0;
      stall_left   <= 0;
      model_rd     <= 0;
      calc_done_q  <= 1'b0;
    end else begin
      mc_load_done <= mc_load_initial && !mc_load_done;
      mc_move_done <= mc_start_move && !mc_move_done;
      if (mc_load_initial && !mc_load_done) begin
        move_cnt    <= 0;
        mc_all_done <= 1'b0;
      end else if (mc_start_move && !mc_move_done) begin
        move_cnt <= move_cnt + 1;
        if (move_cnt + 1 >= moves_target) mc_all_done <= 1'b1;
      end
      calc_done_q <= calc_start && !calc_fast;
      if (stall_left != 0) begin
        stall_left <= stall_left - 1;
      end else if (stall_mode && mem_read_en) begin
        model_rd <= model_rd + 1;
        if (model_rd % 2 == 0) stall_left <= 3;
      end
    end
  end

  // Monitor and scoreboard: expected win_count values are queued when a job
  // is launched and popped on every accepted write.
  logic [WCW-1:0] exp_q[$];
  logic [WCW-1:0] wc_exp;
  bit wc_pending = 0;
  bit prev_rd_stall = 0;
  int rd_acc = 0, calc_pulses = 0, done_pulses = 0, load_seen = 0;
  int strobe_seen = 0, rd_drop = 0, rd_stall_cycles = 0;

  always @(negedge clk) begin
    if (!n_reset) begin
      wc_pending    = 0;
      prev_rd_stall = 0;
    end else begin
      if (wc_pending) begin
        tests_run++;
        if (win_count !== wc_exp) begin
          tests_failed++;
          $display("[TB] FAIL win_count_after_write: got %0d expected %0d", win_count, wc_exp);
        end
        wc_pending = 0;
      end
      if (mem_write_en && !mem_busy) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_write: got a write with win_count %0d, expected none", win_count);
        end else begin
          wc_exp     = exp_q.pop_front();
          wc_pending = 1;
        end
      end
      if (mem_read_en && !mem_busy) rd_acc++;
      if (mem_read_en && mem_busy) rd_stall_cycles++;
      if (prev_rd_stall && !mem_read_en) rd_drop++;
      prev_rd_stall = mem_read_en && mem_busy;
      if (calc_start) calc_pulses++;
      if (done) done_pulses++;
      if (mc_load_initial) load_seen++;
      if (mem_read_en || mem_write_en) strobe_seen++;
    end
  end

  task automatic push_expected(input int n);
    for (int i = 1; i <= n; i++) exp_q.push_back(WCW'(i));
  endtask

  task automatic drive_start(input int w, input int l, input int s, input int d);
    @(negedge clk);
    cfg_width  = DIM_W'(w);
    cfg_length = DIM_W'(l);
    cfg_src    = ADDR_W'(s);
    cfg_dst    = ADDR_W'(d);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok, output int cycles);
    ok = 0;
    cycles = 0;
    while (cycles < limit && !ok) begin
      @(negedge clk);
      cycles++;
      if (done) ok = 1;
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    start = 1'b0;
    cfg_width = '0; cfg_length = '0; cfg_src = '0; cfg_dst = '0;
    #12;
    tests_run++;
    if ({busy, done, err, mem_read_en, mem_write_en, mc_load_initial, mc_start_move, calc_start} !== 8'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes: got %b expected 00000000",
               {busy, done, err, mem_read_en, mem_write_en, mc_load_initial, mc_start_move, calc_start});
    end
    tests_run++;
    if (win_count !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_win_count: got %0d expected 0", win_count);
    end
    tests_run++;
    if ({mc_width, mc_length, mc_initial_addr_r, mc_initial_addr_w} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mc_regs: got %h expected 0",
               {mc_width, mc_length, mc_initial_addr_r, mc_initial_addr_w});
    end
    @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_job();
    int r0 = rd_acc, c0 = calc_pulses, d0 = done_pulses;
    int cyc = 0;
    bit ok = 0;
    moves_target = 8;
    push_expected(9);
    @(negedge clk);
    cfg_width = 12'd5; cfg_length = 12'd5; cfg_src = 8'd100; cfg_dst = 8'd0;
    start = 1'b1;
    while (cyc < 20 && !ok) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (mem_read_en) ok = 1;
    end
    tests_run++;
    if (!ok || cyc != 3) begin
      tests_failed++;
      $display("[TB] FAIL start_to_read_latency: got %0d cycles (seen=%0d) expected 3", cyc, ok);
    end
    tests_run++;
    if (mc_initial_addr_r !== 8'd100 || mc_initial_addr_w !== 8'd0 || mc_width !== 12'd5) begin
      tests_failed++;
      $display("[TB] FAIL basic_mc_regs: got r=%0d w=%0d width=%0d expected 100 0 5",
               mc_initial_addr_r, mc_initial_addr_w, mc_width);
    end
    wait_done(2000, ok, cyc);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL basic_done_timeout: got no done in %0d cycles expected done", cyc);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_after_done: got busy=%b done=%b expected 0 0", busy, done);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (rd_acc - r0 != 27) begin
      tests_failed++;
      $display("[TB] FAIL basic_reads: got %0d expected 27", rd_acc - r0);
    end
    tests_run++;
    if (calc_pulses - c0 != 9) begin
      tests_failed++;
      $display("[TB] FAIL basic_calc_pulses: got %0d expected 9", calc_pulses - c0);
    end
    tests_run++;
    if (done_pulses - d0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL basic_done_pulses: got %0d expected 1", done_pulses - d0);
    end
    tests_run++;
    if (win_count !== 24'd9 || err !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL basic_final: got win_count=%0d err=%b left=%0d expected 9 0 0",
               win_count, err, exp_q.size());
    end
  endtask

  task automatic test_stall();
    int r0 = rd_acc, dr0 = rd_drop, sc0 = rd_stall_cycles;
    int cyc;
    bit ok;
    stall_mode = 1;
    push_expected(9);
    drive_start(5, 5, 100, 0);
    wait_done(4000, ok, cyc);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL stall_done_timeout: got no done in %0d cycles expected done", cyc);
    end
    repeat (3) @(negedge clk);
    stall_mode = 0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (rd_acc - r0 != 27) begin
      tests_failed++;
      $display("[TB] FAIL stall_reads: got %0d expected 27", rd_acc - r0);
    end
    tests_run++;
    if (rd_drop - dr0 != 0 || rd_stall_cycles - sc0 == 0) begin
      tests_failed++;
      $display("[TB] FAIL stall_read_held: got drops=%0d held_cycles=%0d expected 0 and >0",
               rd_drop - dr0, rd_stall_cycles - sc0);
    end
    tests_run++;
    if (win_count !== 24'd9) begin
      tests_failed++;
      $display("[TB] FAIL stall_win_count: got %0d expected 9", win_count);
    end
  endtask

  task automatic test_bad_dims();
    int l0 = load_seen, s0 = strobe_seen, d0 = done_pulses;
    drive_start(2, 5, 7, 9);
    tests_run++;
    if (busy !== 1'b1 || err !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bad_dims_accept: got busy=%b err=%b done=%b expected 1 1 0", busy, err, done);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bad_dims_done: got %b expected 1", done);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bad_dims_after: got done=%b busy=%b err=%b expected 0 0 1", done, busy, err);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (load_seen - l0 != 0 || strobe_seen - s0 != 0 || done_pulses - d0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL bad_dims_activity: got loads=%0d strobes=%0d dones=%0d expected 0 0 1",
               load_seen - l0, strobe_seen - s0, done_pulses - d0);
    end
  endtask

  task automatic test_start_ignored();
    int c0 = calc_pulses, d0 = done_pulses;
    int cyc = 0;
    bit ok = 0;
    push_expected(9);
    drive_start(5, 5, 20, 40);
    while (cyc < 200 && !ok) begin
      @(negedge clk);
      cyc++;
      if (mc_start_move) ok = 1;
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL ignore_move_timeout: got no MOVE in %0d cycles expected MOVE", cyc);
    end
    cfg_width = 12'd9; cfg_length = 12'd7; cfg_src = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (mc_width !== 12'd5 || mc_length !== 12'd5 || mc_initial_addr_r !== 8'd20) begin
      tests_failed++;
      $display("[TB] FAIL ignore_cfg_hold: got w=%0d l=%0d r=%0d expected 5 5 20",
               mc_width, mc_length, mc_initial_addr_r);
    end
    wait_done(2000, ok, cyc);
    repeat (3) @(negedge clk);
    tests_run++;
    if (!ok || win_count !== 24'd9 || calc_pulses - c0 != 9 || done_pulses - d0 != 1 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ignore_job_result: got done=%0d wc=%0d calcs=%0d dones=%0d err=%b expected 1 9 9 1 0",
               ok, win_count, calc_pulses - c0, done_pulses - d0, err);
    end
  endtask

  task automatic test_calc_fast();
    int r0 = rd_acc, c0 = calc_pulses;
    int cyc;
    bit ok;
    calc_fast = 1;
    moves_target = 2;
    push_expected(3);
    drive_start(3, 3, 0, 0);
    wait_done(1000, ok, cyc);
    repeat (3) @(negedge clk);
    tests_run++;
    if (!ok || win_count !== 24'd3 || calc_pulses - c0 != 3 || rd_acc - r0 != 9) begin
      tests_failed++;
      $display("[TB] FAIL calc_fast_job: got done=%0d wc=%0d calcs=%0d reads=%0d expected 1 3 3 9",
               ok, win_count, calc_pulses - c0, rd_acc - r0);
    end
    calc_fast = 0;
    moves_target = 8;
  endtask

  task automatic test_reset_mid_read();
    int d0;
    int cyc = 0;
    bit ok = 0;
    push_expected(9);
    drive_start(5, 5, 100, 0);
    while (cyc < 300 && !ok) begin
      @(negedge clk);
      cyc++;
      if (mem_read_en && win_count == 24'd1) ok = 1;
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL midread_reach: got no second-window READ in %0d cycles expected READ", cyc);
    end
    d0 = done_pulses;
    n_reset = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || mem_read_en !== 1'b0 || win_count !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midread_async_reset: got busy=%b rd=%b wc=%0d expected 0 0 0",
               busy, mem_read_en, win_count);
    end
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    exp_q.delete();
    tests_run++;
    if (done_pulses - d0 != 0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midread_no_done: got %0d pulses expected 0", done_pulses - d0);
    end
    push_expected(9);
    drive_start(5, 5, 100, 0);
    wait_done(2000, ok, cyc);
    repeat (2) @(negedge clk);
    tests_run++;
    if (!ok || win_count !== 24'd9 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midread_rerun: got done=%0d wc=%0d busy=%b expected 1 9 0", ok, win_count, busy);
    end
  endtask

  task automatic test_calc_hang();
    int d0 = done_pulses;
    int cyc = 0;
    bit ok = 0;
    calc_hang = 1;
    push_expected(9);
    drive_start(5, 5, 100, 0);
    while (cyc < 100 && !ok) begin
      @(negedge clk);
      cyc++;
      if (calc_start) ok = 1;
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL hang_reach_calc: got no calc_start in %0d cycles expected one", cyc);
    end
`ifdef SOBEL_SEQ_WATCHDOG_EN
    wait_done(40, ok, cyc);
    tests_run++;
    if (!ok || err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL hang_watchdog: got done=%0d err=%b expected 1 1", ok, err);
    end
    repeat (2) @(negedge clk);
`else
    repeat (300) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || done_pulses - d0 != 0 || mem_write_en !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL hang_stays_calc: got busy=%b dones=%0d wr=%b err=%b expected 1 0 0 0",
               busy, done_pulses - d0, mem_write_en, err);
    end
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
`endif
    calc_hang = 0;
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_stall();
    test_bad_dims();
    test_start_ignored();
    test_calc_fast();
    test_reset_mid_read();
    test_calc_hang();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no completion expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/sobel_sequencer.md
Name: sobel_sequencer

Overview:
Top-level sequencer for the Sobel edge-detection datapath. Accepts a host job (image width/length, source and destination base addresses) and configures the move_control address generator. For each window position it runs read -> compute -> write -> move until move_control reports all_done, then pulses done. It is the only block that drives move_control's load_initial/start_move and the shared memory port's read/write strobes.

Parameters:
ADDR_W, 8, width of source/destination addresses (matches move_control addr_r/addr_w)
DIM_W, 12, width of image width/length fields
READS_PER_WIN, 3, memory reads issued per window position (one new 3-pixel column/row)
WDOG_CYCLES, 255, max cycles in any wait state (optional feature only)

Ports:
clk  in  1  system clock
n_reset  in  1  asynchronous active-low reset
start  in  1  host job request; sampled only in IDLE
cfg_width  in  DIM_W  image width in pixels
cfg_length  in  DIM_W  image length in pixels
cfg_src  in  ADDR_W  source base address
cfg_dst  in  ADDR_W  destination base address
busy  out  1  high from accept until done pulse
done  out  1  one-cycle pulse at job end
err  out  1  sticky job error; cleared on next accepted start
mc_width  out  DIM_W  registered cfg_width to move_control
mc_length  out  DIM_W  registered cfg_length
mc_initial_addr_r  out  ADDR_W  registered cfg_src
mc_initial_addr_w  out  ADDR_W  registered cfg_dst
mc_load_initial  out  1  level, held until mc_load_done
mc_start_move  out  1  level, held until mc_move_done
mc_load_done  in  1  move_control init complete
mc_move_done  in  1  move_control step complete
mc_all_done  in  1  move_control scan complete
mem_read_en  out  1  read strobe, held while mem_busy
mem_write_en  out  1  write strobe, held while mem_busy
mem_busy  in  1  memory stall; strobe accepted on cycle where strobe=1 and mem_busy=0
calc_start  out  1  one-cycle pulse to Sobel kernel
calc_done  in  1  kernel result valid
win_count  out  2*DIM_W  windows written this job

Behaviour:
- Reset: state IDLE; all outputs 0 (mc_* config regs 0, win_count 0, err 0).
- IDLE: start=1 -> latch cfg_* into mc_* regs, clear err and win_count, busy=1; if cfg_width<3 or cfg_length<3 -> err=1, go FINISH (no mc/mem activity); else -> CONFIG.
- CONFIG: mc_load_initial=1 until mc_load_done sampled high; then drop it next cycle, -> READ with read counter rd_cnt=0.
- READ: mem_read_en=1; each accepted read (mem_busy=0) increments rd_cnt; at rd_cnt=READS_PER_WIN-1 accepted -> CALC. Back-to-back accepted reads are allowed, one per cycle.
- CALC: calc_start pulses for exactly the first cycle in state; wait calc_done -> WRITE. calc_done in the pulse cycle itself is honored.
- WRITE: mem_write_en=1 until accepted; on accept win_count++; if mc_all_done=1 -> FINISH, else -> MOVE.
- MOVE: mc_start_move=1 until mc_move_done; -> READ, rd_cnt=0. mc_all_done asserted together with mc_move_done -> still one more READ/CALC/WRITE (final window), then FINISH.
- FINISH: done=1 one cycle, busy=0 next cycle, -> IDLE. mc_* config regs hold last values.
- start while busy: ignored, no queuing. win_count saturates at all-ones.
- n_reset mid-job: immediate return to IDLE, all strobes drop asynchronously; no done pulse.
- Latency: start to first mem_read_en = 2 cycles + move_control load latency.

Optional Feature:
SOBEL_SEQ_WATCHDOG_EN: when defined, a counter reloads on each state entry and counts cycles in CONFIG, READ, CALC, WRITE, MOVE; reaching WDOG_CYCLES forces all strobes low, err=1, -> FINISH (done still pulses). When undefined, no counter logic; waits are unbounded and err is set only by dimension check.

Test Plan:
- Reset mid-READ (n_reset low 2 cycles) -> busy=0, mem_read_en=0, win_count=0 immediately; next start runs normally.
- width=5, length=5, src=100, dst=0, move_control model asserts all_done after 8 moves, no memory stalls -> mc_initial_addr_r=100, 27 accepted reads, 9 calc_start pulses, win_count=9, single done pulse, busy low after.
- Same job with mem_busy high 3 cycles on every 2nd read -> mem_read_en held through stall, read count still 27, win_count=9.
- width=2, length=5 -> err=1, done pulses 2 cycles after start, no mc_load_initial, no mem strobes.
- start re-pulsed during MOVE -> ignored; cfg changes mid-job do not alter mc_width/mc_length.
- (SOBEL_SEQ_WATCHDOG_EN, WDOG_CYCLES=16) calc_done never asserted -> err=1 and done pulse 16 cycles after CALC entry; without macro, sequencer stays in CALC.
